// File: rtl/twiddle_pkg.sv
// Shared types and helpers for the twiddle ROM fetch sequencer.
// The conjugate helper is used only when TWIDDLE_FETCH_INVERSE_EN is defined.
package twiddle_pkg;

    localparam int MAX_FFT_LENGTH_LOG2_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [15:0] cos;
        logic [15:0] sin;
    } tw_word_t;

    typedef struct packed {
        tw_word_t   word;
        logic [3:0] stage;
        logic       last;
    } fifo_entry_t;

    // Two's-complement negate; -(-1.0) is not representable in Q1.15, so it clips.
    function automatic logic [15:0] neg_sat(input logic [15:0] v);
        if (v == 16'h8000) begin
            return 16'h7FFF;
        end
        return (~v) + 16'd1;
    endfunction

endpackage

// File: rtl/twiddle_fetch_ctrl_if.sv
// ROM read port and twiddle stream of the fetch sequencer, bundled as one interface.
// master = sequencer side, slave = ROM / butterfly-engine side.
interface twiddle_fetch_ctrl_if;
    logic [15:0] rom_addr_o;
    logic        rom_addr_valid_o;
    logic [31:0] rom_data_i;
    logic        rom_data_valid_i;
    logic [31:0] tw_data_o;
    logic        tw_valid_o;
    logic        tw_ready_i;
    logic [3:0]  tw_stage_o;
    logic        tw_last_o;

    modport master (
        output rom_addr_o, rom_addr_valid_o,
        input  rom_data_i, rom_data_valid_i,
        output tw_data_o, tw_valid_o, tw_stage_o, tw_last_o,
        input  tw_ready_i
    );

    modport slave (
        input  rom_addr_o, rom_addr_valid_o,
        output rom_data_i, rom_data_valid_i,
        input  tw_data_o, tw_valid_o, tw_stage_o, tw_last_o,
        output tw_ready_i
    );
endinterface

// File: rtl/twiddle_fetch_fifo.sv
// Synchronous FIFO holding ROM returns until the butterfly engine accepts them.
// Storage resets to zero so the head reads as all-zero after reset.
module twiddle_fetch_fifo
    import twiddle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        push_i,
    input  fifo_entry_t wdata_i,
    input  logic        pop_i,
    output fifo_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
                wr_ptr_q                   <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle ROM fetch sequencer for a radix-2 DIT FFT of run-time length 2^L.
// Optional conjugate (IFFT) twiddles: define TWIDDLE_FETCH_INVERSE_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start_i; L and inverse_i captured on start
//   ST_FETCH | walking stage/butterfly, one ROM read per credit
//   ST_DRAIN | all reads issued, waiting for the FIFO to empty
//   ST_DONE  | one-cycle done_o pulse, then back to idle
module twiddle_fetch_ctrl
    import twiddle_pkg::*;
#(
    parameter int MAX_FFT_LENGTH_LOG2 = MAX_FFT_LENGTH_LOG2_DEF,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [3:0]           fft_length_log2_i,
`ifdef TWIDDLE_FETCH_INVERSE_EN
    input  logic                 inverse_i,
`endif
    twiddle_fetch_ctrl_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 len_err_o
);

    localparam int BFLY_W = MAX_FFT_LENGTH_LOG2 - 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          stage_q, stage_d;
    logic [BFLY_W-1:0]   bfly_q, bfly_d;
    logic [CNT_W-1:0]    outst_q, outst_d;
    logic                len_err_q, len_err_d;
    logic                rd_pend_q;
    logic [3:0]          rd_stage_q;
    logic                rd_last_q;
`ifdef TWIDDLE_FETCH_INVERSE_EN
    logic                inv_q, inv_d;
`endif

    logic                len_ok;
    logic [BFLY_W-1:0]   bfly_max;
    logic [BFLY_W-1:0]   jmask;
    logic                bfly_end;
    logic                stage_end;
    logic                pop;
    logic                issue;
    logic                last_issue;
    logic [15:0]         rom_addr;

    fifo_entry_t         push_entry;
    fifo_entry_t         head;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;

    assign len_ok = (fft_length_log2_i != 4'd0) &&
                    (int'(fft_length_log2_i) <= MAX_FFT_LENGTH_LOG2);

    // bfly_max = N/2 - 1 for the captured L; jmask = 2^s - 1 for the current stage.
    always_comb begin
        bfly_max = '0;
        jmask    = '0;
        for (int i = 0; i < BFLY_W; i++) begin
            bfly_max[i] = (i + 1 < int'(len_q));
            jmask[i]    = (i < int'(stage_q));
        end
    end

    assign bfly_end   = (bfly_q == bfly_max);
    assign stage_end  = (stage_q == len_q - 4'd1);
    assign pop        = bus.tw_valid_o && bus.tw_ready_i;
    assign issue      = (state_q == ST_FETCH) &&
                        ((outst_q < CNT_W'(FIFO_DEPTH)) || pop);
    assign last_issue = issue && stage_end && bfly_end;

    // j = b mod 2^s scaled to the Nmax-point ROM, so the table is shared by every L.
    assign rom_addr = 16'(bfly_q & jmask) << (BFLY_W - int'(stage_q));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        len_err_d = len_err_q;
`ifdef TWIDDLE_FETCH_INVERSE_EN
        inv_d     = inv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        state_d   = ST_FETCH;
                        len_d     = fft_length_log2_i;
                        stage_d   = '0;
                        bfly_d    = '0;
                        len_err_d = 1'b0;
`ifdef TWIDDLE_FETCH_INVERSE_EN
                        inv_d     = inverse_i;
`endif
                    end else begin
                        state_d   = ST_DONE;
                        len_err_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                        stage_d = '0;
                        bfly_d  = '0;
                    end else if (bfly_end) begin
                        stage_d = stage_q + 4'd1;
                        bfly_d  = '0;
                    end else begin
                        bfly_d  = bfly_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the final pop so done_o lands one cycle after it.
                if ((outst_q == '0) || ((outst_q == CNT_W'(1)) && pop)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        outst_d = outst_q + CNT_W'(issue) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            stage_q    <= '0;
            bfly_q     <= '0;
            outst_q    <= '0;
            len_err_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_stage_q <= '0;
            rd_last_q  <= 1'b0;
`ifdef TWIDDLE_FETCH_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            outst_q    <= outst_d;
            len_err_q  <= len_err_d;
            rd_pend_q  <= issue;
            rd_stage_q <= stage_q;
            rd_last_q  <= last_issue;
`ifdef TWIDDLE_FETCH_INVERSE_EN
            inv_q      <= inv_d;
`endif
        end
    end

    // A return with no read in flight (e.g. straddling a reset) is dropped.
    assign fifo_push = bus.rom_data_valid_i && rd_pend_q && !fifo_full;

    always_comb begin
        push_entry.word  = tw_word_t'(bus.rom_data_i);
        push_entry.stage = rd_stage_q;
        push_entry.last  = rd_last_q;
`ifdef TWIDDLE_FETCH_INVERSE_EN
        if (inv_q) begin
            push_entry.word.sin = neg_sat(bus.rom_data_i[15:0]);
        end
`endif
    end

    twiddle_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (fifo_push),
        .wdata_i   (push_entry),
        .pop_i     (pop),
        .rdata_o   (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign bus.rom_addr_o       = rom_addr;
    assign bus.rom_addr_valid_o = issue;
    assign bus.tw_valid_o       = !fifo_empty;
    assign bus.tw_data_o        = head.word;
    assign bus.tw_stage_o       = head.stage;
    assign bus.tw_last_o        = head.last && !fifo_empty;

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign len_err_o = len_err_q;

endmodule

// File: tb/tb_twiddle_fetch_ctrl.sv
// Self-checking bench for twiddle_fetch_ctrl with a 1-cycle ROM model and a
// loop-order reference model; inverse cases run when TWIDDLE_FETCH_INVERSE_EN is defined.
module tb_twiddle_fetch_ctrl;

    localparam int MAXL  = 12;
    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  stage;
        logic        last;
    } exp_e_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] fft_len;
    logic       busy;
    logic       done;
    logic       len_err;
`ifdef TWIDDLE_FETCH_INVERSE_EN
    logic       inverse;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rom_mode = 0;
    bit inv_en = 1'b0;

    twiddle_fetch_ctrl_if bus_if();

    always #5 clk = ~clk;

    twiddle_fetch_ctrl #(
        .MAX_FFT_LENGTH_LOG2 (MAXL),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .start_i           (start),
        .fft_length_log2_i (fft_len),
`ifdef TWIDDLE_FETCH_INVERSE_EN
        .inverse_i         (inverse),
`endif
        .bus               (bus_if),
        .busy_o            (busy),
        .done_o            (done),
        .len_err_o         (len_err)
    );

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        case (rom_mode)
            1:       return 32'h5A82_5A82;
            2:       return 32'h1234_8000;
            default: return {a + 16'h1357, a ^ 16'hC3A5};
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [15:0] a);
        logic [31:0] w;
        int          s;
        w = rom_word(a);
        if (!inv_en) return w;
        s = -int'($signed(w[15:0]));
        if (s > 32767) s = 32767;
        return {w[31:16], s[15:0]};
    endfunction

    // ROM: fixed 1-cycle read latency, never stalls.
    always @(posedge clk) begin
        bus_if.rom_data_valid_i <= bus_if.rom_addr_valid_o;
        bus_if.rom_data_i       <= bus_if.rom_addr_valid_o ? rom_word(bus_if.rom_addr_o) : 32'h0BAD_F00D;
    end

    task automatic run_xfer(input int L, input int ready_pct, input int pulse_at,
                            output int n_tw, output int n_rd, output int first_valid,
                            output int done_cyc, output logic [31:0] last_data);
        exp_e_t      exp_a[$];
        exp_e_t      exp_t[$];
        exp_e_t      e;
        bit          valid_len;
        bit          rdy;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [3:0]  prev_stage;
        logic        prev_last;
        int          budget;
        int          last_hs;
        valid_len = (L >= 1) && (L <= MAXL);
        if (valid_len) begin
            for (int s = 0; s < L; s++) begin
                for (int b = 0; b < (1 << (L - 1)); b++) begin
                    e.addr  = 16'((b % (1 << s)) << (MAXL - 1 - s));
                    e.stage = 4'(s);
                    e.last  = (s == L - 1) && (b == (1 << (L - 1)) - 1);
                    exp_a.push_back(e);
                    exp_t.push_back(e);
                end
            end
        end
        n_tw = 0; n_rd = 0; first_valid = -1; done_cyc = -1; last_hs = -1;
        last_data = '0; prev_stall = 1'b0;
        prev_data = '0; prev_stage = '0; prev_last = 1'b0;
        budget = 3 * exp_a.size() + 50;
        @(negedge clk);
        start = 1'b1;
        fft_len = 4'(L);
        bus_if.tw_ready_i = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = (cyc == pulse_at);
            if (cyc == pulse_at) fft_len = 4'd2;
            rdy = ($urandom_range(0, 99) < ready_pct);
            bus_if.tw_ready_i = rdy;
            #1;
            if (cyc == 1) begin
                n_cmp++;
                if (len_err !== !valid_len) begin
                    n_err++; $display("FAIL len_err L=%0d: got %b want %b", L, len_err, !valid_len);
                end
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++; $display("FAIL busy L=%0d: got %b want 1", L, busy);
                end
            end
            if (bus_if.rom_addr_valid_o === 1'b1) begin
                n_rd++;
                n_cmp++;
                if (exp_a.size() == 0) begin
                    n_err++; $display("FAIL extra_read L=%0d: got addr %h want no read", L, bus_if.rom_addr_o);
                end else begin
                    e = exp_a.pop_front();
                    if (bus_if.rom_addr_o !== e.addr) begin
                        n_err++; $display("FAIL rom_addr L=%0d read %0d: got %h want %h", L, n_rd, bus_if.rom_addr_o, e.addr);
                    end
                end
            end
            if (prev_stall) begin
                n_cmp++;
                if (bus_if.tw_valid_o !== 1'b1 || bus_if.tw_data_o !== prev_data ||
                    bus_if.tw_stage_o !== prev_stage || bus_if.tw_last_o !== prev_last) begin
                    n_err++; $display("FAIL stall_hold L=%0d: got v=%b d=%h want v=1 d=%h", L, bus_if.tw_valid_o, bus_if.tw_data_o, prev_data);
                end
            end
            if (bus_if.tw_valid_o === 1'b1 && first_valid < 0) first_valid = cyc;
            if (bus_if.tw_valid_o === 1'b1 && rdy) begin
                n_tw++;
                last_hs = cyc;
                last_data = bus_if.tw_data_o;
                n_cmp++;
                if (exp_t.size() == 0) begin
                    n_err++; $display("FAIL extra_twiddle L=%0d: got %h want none", L, bus_if.tw_data_o);
                end else begin
                    e = exp_t.pop_front();
                    if (bus_if.tw_data_o !== exp_word(e.addr) || bus_if.tw_stage_o !== e.stage ||
                        bus_if.tw_last_o !== e.last) begin
                        n_err++; $display("FAIL twiddle L=%0d #%0d: got d=%h s=%0d l=%b want d=%h s=%0d l=%b",
                                          L, n_tw, bus_if.tw_data_o, bus_if.tw_stage_o, bus_if.tw_last_o,
                                          exp_word(e.addr), e.stage, e.last);
                    end
                end
            end
            n_cmp++;
            if (n_rd - n_tw > DEPTH) begin
                n_err++; $display("FAIL outstanding L=%0d: got %0d want <= %0d", L, n_rd - n_tw, DEPTH);
            end
            prev_stall = (bus_if.tw_valid_o === 1'b1) && !rdy;
            prev_data  = bus_if.tw_data_o;
            prev_stage = bus_if.tw_stage_o;
            prev_last  = bus_if.tw_last_o;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (done_cyc != (valid_len ? last_hs + 1 : 1)) begin
            n_err++; $display("FAIL done_timing L=%0d: got cycle %0d want %0d", L, done_cyc, valid_len ? last_hs + 1 : 1);
        end
        n_cmp++;
        if (exp_t.size() != 0 || exp_a.size() != 0) begin
            n_err++; $display("FAIL missing L=%0d: got %0d/%0d pending want 0", L, exp_a.size(), exp_t.size());
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL after_done L=%0d: got done=%b busy=%b want 0 0", L, done, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || len_err !== 1'b0) begin
            n_err++; $display("FAIL reset_status: got %b%b%b want 000", busy, done, len_err);
        end
        n_cmp++;
        if (bus_if.rom_addr_valid_o !== 1'b0 || bus_if.rom_addr_o !== 16'h0) begin
            n_err++; $display("FAIL reset_rom: got v=%b a=%h want 0 0", bus_if.rom_addr_valid_o, bus_if.rom_addr_o);
        end
        n_cmp++;
        if (bus_if.tw_valid_o !== 1'b0 || bus_if.tw_data_o !== 32'h0 || bus_if.tw_stage_o !== 4'h0 || bus_if.tw_last_o !== 1'b0) begin
            n_err++; $display("FAIL reset_tw: got v=%b d=%h s=%h l=%b want zeros", bus_if.tw_valid_o, bus_if.tw_data_o, bus_if.tw_stage_o, bus_if.tw_last_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_l3_full_rate();
        int n_tw, n_rd, fv, dc;
        logic [31:0] ld;
        run_xfer(3, 100, 0, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (n_tw != 12 || n_rd != 12) begin
            n_err++; $display("FAIL l3_count: got tw=%0d rd=%0d want 12 12", n_tw, n_rd);
        end
        n_cmp++;
        if (fv != 3) begin
            n_err++; $display("FAIL l3_first_valid: got cycle %0d want 3", fv);
        end
        n_cmp++;
        if (dc != 15) begin
            n_err++; $display("FAIL l3_done: got cycle %0d want 15", dc);
        end
    endtask

    task automatic test_l12_backpressure();
        int n_tw, n_rd, fv, dc;
        logic [31:0] ld;
        run_xfer(12, 50, 0, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (n_tw != 24576) begin
            n_err++; $display("FAIL l12_count: got %0d want 24576", n_tw);
        end
    endtask

    task automatic test_invalid_len();
        int n_tw, n_rd, fv, dc;
        int bad[2] = '{0, 13};
        logic [31:0] ld;
        foreach (bad[i]) begin
            run_xfer(bad[i], 100, 0, n_tw, n_rd, fv, dc, ld);
            n_cmp++;
            if (n_tw != 0 || n_rd != 0) begin
                n_err++; $display("FAIL invalid_reads L=%0d: got tw=%0d rd=%0d want 0 0", bad[i], n_tw, n_rd);
            end
            n_cmp++;
            if (len_err !== 1'b1) begin
                n_err++; $display("FAIL len_err_sticky L=%0d: got %b want 1", bad[i], len_err);
            end
        end
        run_xfer(2, 100, 0, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (len_err !== 1'b0 || n_tw != 4) begin
            n_err++; $display("FAIL len_err_clear: got err=%b tw=%0d want 0 4", len_err, n_tw);
        end
    endtask

    task automatic test_start_ignored();
        int n_tw, n_rd, fv, dc;
        logic [31:0] ld;
        run_xfer(4, 70, 5, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (n_tw != 32 || n_rd != 32) begin
            n_err++; $display("FAIL start_ignored: got tw=%0d rd=%0d want 32 32", n_tw, n_rd);
        end
    endtask

    task automatic test_reset_mid();
        int rd = 0;
        int cyc = 0;
        int n_tw, n_rd, fv, dc;
        logic [31:0] ld;
        @(negedge clk);
        start = 1'b1;
        fft_len = 4'd10;
        bus_if.tw_ready_i = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rd < 5 * 512 + 37 && cyc < 4000) begin
            #1;
            if (bus_if.rom_addr_valid_o === 1'b1) rd++;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (rd < 5 * 512 + 37) begin
            n_err++; $display("FAIL reset_mid_reach: got %0d reads want %0d", rd, 5 * 512 + 37);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || len_err !== 1'b0 || bus_if.rom_addr_valid_o !== 1'b0 || bus_if.rom_addr_o !== 16'h0) begin
            n_err++; $display("FAIL reset_mid_ctrl: got b=%b d=%b e=%b v=%b a=%h want zeros", busy, done, len_err, bus_if.rom_addr_valid_o, bus_if.rom_addr_o);
        end
        n_cmp++;
        if (bus_if.tw_valid_o !== 1'b0 || bus_if.tw_data_o !== 32'h0 || bus_if.tw_stage_o !== 4'h0 || bus_if.tw_last_o !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_tw: got v=%b d=%h s=%h l=%b want zeros", bus_if.tw_valid_o, bus_if.tw_data_o, bus_if.tw_stage_o, bus_if.tw_last_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus_if.tw_valid_o !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL stray_return: got v=%b busy=%b want 0 0", bus_if.tw_valid_o, busy);
        end
        run_xfer(1, 100, 0, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (n_tw != 1 || n_rd != 1) begin
            n_err++; $display("FAIL post_reset_l1: got tw=%0d rd=%0d want 1 1", n_tw, n_rd);
        end
    endtask

    task automatic test_random_lengths();
        int n_tw, n_rd, fv, dc, L, pct;
        logic [31:0] ld;
        for (int k = 0; k < 4; k++) begin
            L   = int'($urandom_range(1, 9));
            pct = int'($urandom_range(25, 100));
            run_xfer(L, pct, 0, n_tw, n_rd, fv, dc, ld);
            n_cmp++;
            if (n_tw != L * (1 << (L - 1))) begin
                n_err++; $display("FAIL random_len L=%0d: got %0d want %0d", L, n_tw, L * (1 << (L - 1)));
            end
        end
    endtask

`ifdef TWIDDLE_FETCH_INVERSE_EN
    task automatic test_inverse();
        int n_tw, n_rd, fv, dc;
        logic [31:0] ld;
        inverse = 1'b1;
        inv_en = 1'b1;
        rom_mode = 1;
        run_xfer(1, 100, 0, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (ld !== 32'h5A82_A57E) begin
            n_err++; $display("FAIL inverse_conj: got %h want 5a82a57e", ld);
        end
        rom_mode = 2;
        run_xfer(1, 100, 0, n_tw, n_rd, fv, dc, ld);
        n_cmp++;
        if (ld !== 32'h1234_7FFF) begin
            n_err++; $display("FAIL inverse_sat: got %h want 12347fff", ld);
        end
        rom_mode = 0;
        run_xfer(3, 60, 0, n_tw, n_rd, fv, dc, ld);
        inverse = 1'b0;
        inv_en = 1'b0;
        run_xfer(2, 100, 0, n_tw, n_rd, fv, dc, ld);
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        fft_len = 4'd0;
        bus_if.tw_ready_i = 1'b0;
`ifdef TWIDDLE_FETCH_INVERSE_EN
        inverse = 1'b0;
`endif
        test_reset();
        test_l3_full_rate();
        test_invalid_len();
        test_start_ignored();
        test_reset_mid();
        test_random_lengths();
`ifdef TWIDDLE_FETCH_INVERSE_EN
        test_inverse();
`endif
        test_l12_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
